// File: rtl/uart_rx_unit.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_unit
//  Purpose  : Oversampling UART receiver (8N1) with a first-word fall-through
//             receive FIFO. Define UART_RX_PARITY_EN for 8E1 framing.
//  Revision : 1.0  initial release
// ============================================================================
module uart_rx_unit #(
   parameter int FIFO_AW = 2,
   parameter int OVS     = 16
) (
   input  logic       clk,
   input  logic       Reset,
   input  logic [9:0] divsr,
   input  logic       rx,
   input  logic       rd_uart,
   output logic [7:0] r_data,
   output logic       rx_empty,
   output logic       frame_err,
   output logic       overrun
);

   localparam int         c_DEPTH = 1 << FIFO_AW;
   localparam logic [3:0] c_S_MID = 4'(OVS / 2 - 1);
   localparam logic [3:0] c_S_END = 4'(OVS - 1);

`ifdef UART_RX_PARITY_EN
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } state_t;
`else
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_STOP   = 3'd4
   } state_t;
`endif

   // ---------------------------------------------------------------- baud tick
   logic [9:0] r_tick_cnt;
   logic       w_tick;

   assign w_tick = (r_tick_cnt == divsr);

   // ">=" lets a shrinking divisor wrap the counter immediately
   always_ff @(posedge clk) begin
      if (Reset)
         r_tick_cnt <= '0;
      else if (r_tick_cnt >= divsr)
         r_tick_cnt <= '0;
      else
         r_tick_cnt <= r_tick_cnt + 10'd1;
   end

   // ------------------------------------------------------------ synchronizer
   logic r_rx_meta;
   logic r_rx_s;

   always_ff @(posedge clk) begin
      if (Reset) begin
         r_rx_meta <= 1'b1;
         r_rx_s    <= 1'b1;
      end else begin
         r_rx_meta <= rx;
         r_rx_s    <= r_rx_meta;
      end
   end

   // ----------------------------------------------------------- frame decoder
   state_t     r_state, w_state_nxt;
   logic [3:0] r_s, w_s_nxt;
   logic [2:0] r_n, w_n_nxt;
   logic [7:0] r_b, w_b_nxt;
   logic       w_par_ok;
   logic       w_accept;
   logic       w_reject;

`ifdef UART_RX_PARITY_EN
   logic r_par, w_par_nxt;
   assign w_par_ok = (r_par == (^r_b));
`else
   assign w_par_ok = 1'b1;
`endif

   always_ff @(posedge clk) begin
      if (Reset) begin
         r_state <= ST_IDLE;
         r_s     <= '0;
         r_n     <= '0;
         r_b     <= '0;
`ifdef UART_RX_PARITY_EN
         r_par   <= 1'b0;
`endif
      end else begin
         r_state <= w_state_nxt;
         r_s     <= w_s_nxt;
         r_n     <= w_n_nxt;
         r_b     <= w_b_nxt;
`ifdef UART_RX_PARITY_EN
         r_par   <= w_par_nxt;
`endif
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_s_nxt     = r_s;
      w_n_nxt     = r_n;
      w_b_nxt     = r_b;
      w_accept    = 1'b0;
      w_reject    = 1'b0;
`ifdef UART_RX_PARITY_EN
      w_par_nxt   = r_par;
`endif
      case (r_state)
         ST_IDLE: begin
            if (!r_rx_s) begin
               w_state_nxt = ST_START;
               w_s_nxt     = '0;
            end
         end
         ST_START: begin
            if (w_tick) begin
               if (r_s == c_S_MID) begin
                  // line back high at mid start bit: treat as a glitch
                  if (!r_rx_s) begin
                     w_state_nxt = ST_DATA;
                     w_s_nxt     = '0;
                     w_n_nxt     = '0;
                  end else begin
                     w_state_nxt = ST_IDLE;
                  end
               end else begin
                  w_s_nxt = r_s + 4'd1;
               end
            end
         end
         ST_DATA: begin
            if (w_tick) begin
               if (r_s == c_S_END) begin
                  w_b_nxt = {r_rx_s, r_b[7:1]};
                  w_s_nxt = '0;
                  if (r_n == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                     w_state_nxt = ST_PARITY;
`else
                     w_state_nxt = ST_STOP;
`endif
                  end else begin
                     w_n_nxt = r_n + 3'd1;
                  end
               end else begin
                  w_s_nxt = r_s + 4'd1;
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         ST_PARITY: begin
            if (w_tick) begin
               if (r_s == c_S_END) begin
                  w_par_nxt   = r_rx_s;
                  w_s_nxt     = '0;
                  w_state_nxt = ST_STOP;
               end else begin
                  w_s_nxt = r_s + 4'd1;
               end
            end
         end
`endif
         ST_STOP: begin
            if (w_tick) begin
               if (r_s == c_S_END) begin
                  if (r_rx_s && w_par_ok)
                     w_accept = 1'b1;
                  else
                     w_reject = 1'b1;
                  w_s_nxt     = '0;
                  w_state_nxt = ST_IDLE;
               end else begin
                  w_s_nxt = r_s + 4'd1;
               end
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_s_nxt     = '0;
            w_n_nxt     = '0;
         end
      endcase
   end

   // Accepted byte is staged one cycle before it reaches the FIFO
   logic       r_push;
   logic [7:0] r_push_data;
   logic       r_frame_err;

   always_ff @(posedge clk) begin
      if (Reset) begin
         r_push      <= 1'b0;
         r_push_data <= '0;
         r_frame_err <= 1'b0;
      end else begin
         r_push      <= w_accept;
         r_push_data <= r_b;
         r_frame_err <= w_reject;
      end
   end

   // ------------------------------------------------------------ receive FIFO
   logic [7:0]         r_mem [c_DEPTH];
   logic [FIFO_AW-1:0] r_wptr;
   logic [FIFO_AW-1:0] r_rptr;
   logic [FIFO_AW:0]   r_count;
   logic [7:0]         r_hold;
   logic               r_overrun;
   logic               w_full;
   logic               w_empty;
   logic               w_wr;
   logic               w_rd;

   assign w_full  = (r_count == (FIFO_AW + 1)'(c_DEPTH));
   assign w_empty = (r_count == '0);
   assign w_wr    = r_push && (!w_full || rd_uart);
   assign w_rd    = rd_uart && !w_empty;

   always_ff @(posedge clk) begin
      if (w_wr)
         r_mem[r_wptr] <= r_push_data;
   end

   always_ff @(posedge clk) begin
      if (Reset) begin
         r_wptr    <= '0;
         r_rptr    <= '0;
         r_count   <= '0;
         r_hold    <= '0;
         r_overrun <= 1'b0;
      end else begin
         r_overrun <= r_push && w_full && !rd_uart;
         if (w_wr)
            r_wptr <= r_wptr + 1'b1;
         if (w_rd) begin
            r_rptr <= r_rptr + 1'b1;
            r_hold <= r_mem[r_rptr];
         end
         case ({w_wr, w_rd})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // While empty, show the last byte handed out so the output never wanders
   assign r_data    = w_empty ? r_hold : r_mem[r_rptr];
   assign rx_empty  = w_empty;
   assign frame_err = r_frame_err;
   assign overrun   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_rx_unit
//  Purpose  : Scoreboard bench for uart_rx_unit (divsr=9, 160 clocks per bit).
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_rx_unit;

   localparam int BT = 160;

   logic       clk = 1'b0;
   logic       Reset;
   logic [9:0] divsr;
   logic       rx;
   logic       rd_uart;
   logic [7:0] r_data;
   logic       rx_empty;
   logic       frame_err;
   logic       overrun;

   always #5 clk = ~clk;

   uart_rx_unit #(.FIFO_AW(2), .OVS(16)) dut (
      .clk       (clk),
      .Reset     (Reset),
      .divsr     (divsr),
      .rx        (rx),
      .rd_uart   (rd_uart),
      .r_data    (r_data),
      .rx_empty  (rx_empty),
      .frame_err (frame_err),
      .overrun   (overrun)
   );

   int         total  = 0;
   int         bad    = 0;
   int         fe_cnt = 0;
   int         ov_cnt = 0;
   bit         rd_en  = 1'b0;
   logic [7:0] exp_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
      end
   endtask

   task automatic drive(input logic v, input int n);
      rx = v;
      repeat (n) @(negedge clk);
   endtask

   // par_flip inverts the (even) parity bit on parity builds
   task automatic send(input logic [7:0] d, input logic stop, input logic par_flip);
      logic pbit;
      pbit = (^d) ^ par_flip;
      drive(1'b0, BT);
      for (int i = 0; i < 8; i++)
         drive(d[i], BT);
`ifdef UART_RX_PARITY_EN
      drive(pbit, BT);
`endif
      if (stop) begin
         drive(1'b1, BT);
         drive(1'b1, 40);
      end else begin
         drive(1'b0, 100);
         drive(1'b1, 2 * BT);
      end
   endtask

   task automatic drain(input string name);
      int  cyc;
      bit  done;
      done  = 1'b0;
      rd_en = 1'b1;
      for (cyc = 0; cyc < 400 && !done; cyc++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && rx_empty && !rd_uart)
            done = 1'b1;
      end
      rd_en = 1'b0;
      repeat (3) @(negedge clk);
      if (!done) begin
         total++;
         bad++;
         $display("FAIL %s_timeout: got %0d bytes pending required 0", name, exp_q.size());
      end
   endtask

   // Scoreboard monitor: pops and compares whenever the FIFO presents a byte
   initial begin
      rd_uart = 1'b0;
      forever begin
         @(negedge clk);
         if (rd_en && !rx_empty && !Reset) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_byte: got 0x%0h required none", r_data);
            end else begin
               check("fifo_data", {24'd0, r_data}, {24'd0, exp_q.pop_front()});
            end
            rd_uart = 1'b1;
            @(negedge clk);
            rd_uart = 1'b0;
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (frame_err) fe_cnt++;
         if (overrun)   ov_cnt++;
      end
   end

   initial begin
      Reset = 1'b1;
      rx    = 1'b1;
      divsr = 10'd9;
      repeat (3) @(negedge clk);
      check("reset_empty", {31'd0, rx_empty}, 32'd1);
      check("reset_rdata", {24'd0, r_data}, 32'd0);
      check("reset_frame_err", {31'd0, frame_err}, 32'd0);
      check("reset_overrun", {31'd0, overrun}, 32'd0);
      Reset = 1'b0;
      drive(1'b1, 50);

      // valid frame
      send(8'hA5, 1'b1, 1'b0);
      check("a5_not_empty", {31'd0, rx_empty}, 32'd0);
      check("a5_head", {24'd0, r_data}, 32'h0000_00A5);
      check("a5_no_frame_err", fe_cnt, 32'd0);
      exp_q.push_back(8'hA5);
      drain("a5");
      check("a5_empty_after_pop", {31'd0, rx_empty}, 32'd1);
      check("a5_rdata_held", {24'd0, r_data}, 32'h0000_00A5);

      // bad stop bit
      send(8'h3C, 1'b0, 1'b0);
      check("3c_frame_err_count", fe_cnt, 32'd1);
      check("3c_still_empty", {31'd0, rx_empty}, 32'd1);

      // short low glitch
      drive(1'b0, 3);
      drive(1'b1, 3 * BT);
      check("glitch_no_frame_err", fe_cnt, 32'd1);
      check("glitch_no_push", {31'd0, rx_empty}, 32'd1);
      send(8'h5A, 1'b1, 1'b0);
      exp_q.push_back(8'h5A);
      drain("5a");

      // fill past capacity
      for (int i = 1; i <= 4; i++) begin
         send(8'(i), 1'b1, 1'b0);
         exp_q.push_back(8'(i));
      end
      check("fill4_no_overrun", ov_cnt, 32'd0);
      send(8'h05, 1'b1, 1'b0);
      check("fill5_overrun_once", ov_cnt, 32'd1);
      check("fill5_head", {24'd0, r_data}, 32'h0000_0001);
      drain("fill");
      check("fill_empty_after_pops", {31'd0, rx_empty}, 32'd1);
      check("fill_rdata_held", {24'd0, r_data}, 32'h0000_0004);

      // reset in the middle of bit 4
      drive(1'b0, BT);
      for (int i = 0; i < 4; i++)
         drive(1'b0, BT);
      drive(1'b0, 80);
      Reset = 1'b1;
      rx    = 1'b1;
      repeat (3) @(negedge clk);
      Reset = 1'b0;
      drive(1'b1, 2 * BT);
      check("midreset_empty", {31'd0, rx_empty}, 32'd1);
      check("midreset_rdata_zero", {24'd0, r_data}, 32'd0);
      check("midreset_no_frame_err", fe_cnt, 32'd1);
      send(8'hFF, 1'b1, 1'b0);
      exp_q.push_back(8'hFF);
      drain("ff");

`ifdef UART_RX_PARITY_EN
      send(8'h07, 1'b1, 1'b0);
      exp_q.push_back(8'h07);
      drain("par_good");
      send(8'h07, 1'b1, 1'b1);
      check("par_bad_frame_err", fe_cnt, 32'd2);
      check("par_bad_no_push", {31'd0, rx_empty}, 32'd1);
`endif

      check("final_overrun_count", ov_cnt, 32'd1);
      check("scoreboard_empty", exp_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
